vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_axis_counter.sv | 45 ++++
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared defaults for the VGA timing generator: 640x480@60 timing,
// colour/coordinate widths and a small helper for axis period length.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_CW = 10;
  localparam int DEF_XW = 11;

  // Full period of one axis (visible + front porch + sync + back porch).
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): a wrapping position counter
// plus combinational decodes of the wrap point, sync window and active area.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int   ACTIVE = DEF_H_ACTIVE,
  parameter int   FP     = DEF_H_FP,
  parameter int   SYNC   = DEF_H_SYNC,
  parameter int   BP     = DEF_H_BP,
  parameter logic POL    = 1'b0,
  parameter int   XW     = DEF_XW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [XW-1:0] count,
  output logic          wrap,
  output logic          sync,
  output logic          active
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [XW-1:0] LAST    = XW'(TOTAL - 1);
  localparam logic [XW-1:0] SYNC_LO = XW'(ACTIVE + FP);
  localparam logic [XW-1:0] SYNC_HI = XW'(ACTIVE + FP + SYNC - 1);
  localparam logic [XW-1:0] ACT_END = XW'(ACTIVE);

  // Position counter: advances on enable, wraps from TOTAL-1 back to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + XW'(1);
    end
  end

  // Decodes of the current position.
  always_comb begin
    wrap   = (count == LAST);
    sync   = ((count >= SYNC_LO) && (count <= SYNC_HI)) ? POL : ~POL;
    active = (count < ACT_END);
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal/vertical counters, registered
// coordinates, syncs, active flag and start pulses, plus DAC side signals.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = DEF_CW,
  parameter int   XW       = DEF_XW
) (
  input  logic          CLK25,
  input  logic          reset,
  input  logic          pix_en,
  input  logic [CW-1:0] in_r,
  input  logic [CW-1:0] in_g,
  input  logic [CW-1:0] in_b,
  output logic [XW-1:0] px,
  output logic [XW-1:0] py,
  output logic [CW-1:0] vga_r,
  output logic [CW-1:0] vga_g,
  output logic [CW-1:0] vga_b,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_cnt,
  output logic          vga_blank,
  output logic          vga_sync,
  output logic          vga_clk
);

  logic [XW-1:0] hcount;
  logic [XW-1:0] vcount;
  logic          h_wrap;
  logic          v_wrap;
  logic          h_sync_lvl;
  logic          v_sync_lvl;
  logic          h_active;
  logic          v_active;
  logic          v_en;

  assign v_en = pix_en & h_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL),
    .XW     (XW)
  ) u_h_axis (
    .clk    (CLK25),
    .rst    (reset),
    .en     (pix_en),
    .count  (hcount),
    .wrap   (h_wrap),
    .sync   (h_sync_lvl),
    .active (h_active)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL),
    .XW     (XW)
  ) u_v_axis (
    .clk    (CLK25),
    .rst    (reset),
    .en     (v_en),
    .count  (vcount),
    .wrap   (v_wrap),
    .sync   (v_sync_lvl),
    .active (v_active)
  );

  // Output registers: all sampled from the same hcount/vcount so they stay
  // mutually aligned one enabled cycle behind the counters.
  always_ff @(posedge CLK25 or posedge reset) begin
    if (reset) begin
      px          <= '0;
      py          <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else if (pix_en) begin
      px          <= hcount;
      py          <= vcount;
      hsync       <= h_sync_lvl;
      vsync       <= v_sync_lvl;
      video_on    <= h_active & v_active;
      line_start  <= (hcount == '0);
      frame_start <= (hcount == '0) && (vcount == '0);
      if (h_wrap && v_wrap) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  // Colour gating and DAC control.
  always_comb begin
    vga_r     = video_on ? in_r : '0;
    vga_g     = video_on ? in_g : '0;
    vga_b     = video_on ? in_b : '0;
    vga_blank = video_on;
    vga_sync  = 1'b0;
    vga_clk   = ~CLK25;
  end

endmodule
